// File: rtl/pc_sequencer.sv
// Program-counter sequencer: a fetch/execute FSM that steps the PC sequentially,
// on taken branches and on jumps, stops on halt, and counts taken branches.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        halt,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_target,
  output logic [31:0] pc,
  output logic        pc_src,
  output logic [15:0] taken_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [15:0] r_taken_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_pc;
  logic [31:0] w_jump_pc;
  logic        w_exec_fire;
  logic        w_pc_src;
  logic        w_count_inc;

  assign w_pc_plus4  = r_pc + 32'd4;
  // Word offset becomes a byte offset; upper offset bits fall off modulo 2^32.
  assign w_branch_pc = w_pc_plus4 + {branch_offset[29:0], 2'b00};
  assign w_jump_pc   = {w_pc_plus4[31:28], jump_target, 2'b00};

  // Completion qualifiers only mean anything while executing.
  assign w_exec_fire = (r_state == ST_EXEC) && exec_done;
  assign w_pc_src    = w_exec_fire && branch && zero && !jump;
  assign w_count_inc = w_pc_src && !halt;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            w_state_next = ST_HALTED;
          end else begin
            w_state_next = ST_FETCH;
            if (jump)          w_pc_next = w_jump_pc;
            else if (w_pc_src) w_pc_next = w_branch_pc;
            else               w_pc_next = w_pc_plus4;
          end
        end
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_taken_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_count_inc && (r_taken_count != 16'hFFFF))
        r_taken_count <= r_taken_count + 16'd1;
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_EXEC);
  assign pc          = r_pc;
  assign pc_src      = w_pc_src;
  assign taken_count = r_taken_count;
  assign state       = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: each retired instruction pushes its
// expected pc/count/state, which is popped and compared after the retire edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic        imem_ack;
  logic        instr_valid;
  logic        exec_done;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        halt;
  logic [31:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] pc;
  logic        pc_src;
  logic [15:0] taken_count;
  logic [1:0]  state;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .halt         (halt),
    .branch_offset(branch_offset),
    .jump_target  (jump_target),
    .pc           (pc),
    .pc_src       (pc_src),
    .taken_count  (taken_count),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_fail;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  // Per-instruction observations handed back by the issue helper.
  exp_t        obs_post;
  int          obs_req;
  logic [1:0]  obs_st_exec;
  logic        obs_iv;
  logic        obs_psrc;
  logic [31:0] obs_pc_exec;
  exp_t        e;

  function automatic logic [31:0] model_next_pc(input logic [31:0] p, input logic br,
      input logic z, input logic j, input logic [31:0] off, input logic [25:0] tgt);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (j) return {p4[31:28], tgt, 2'b00};
    if (br && z) return p4 + (off << 2);
    return p4;
  endfunction

  task automatic clear_inputs();
    start = 0; imem_ack = 0; exec_done = 0; branch = 0; zero = 0;
    jump = 0; halt = 0; branch_offset = '0; jump_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    m_pc  = RST_PC;
    m_cnt = 16'd0;
    sb.delete();
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Drives one instruction from FETCH through its EXEC completion edge and
  // pushes the expected post-retire values to the scoreboard.
  task automatic issue(input logic br, input logic z, input logic j, input logic h,
      input logic [31:0] off, input logic [25:0] tgt, input int wait_cyc);
    exp_t x;
    obs_req = 0;
    for (int k = 0; k < wait_cyc; k++) begin
      if (imem_req) obs_req++;
      exec_done = 1; jump = 1; halt = 1; branch = 1; zero = 1;
      @(negedge clk);
    end
    exec_done = 0; jump = 0; halt = 0; branch = 0; zero = 0;
    if (imem_req) obs_req++;
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    branch = br; zero = z; jump = j; halt = h;
    branch_offset = off; jump_target = tgt;
    @(negedge clk);
    obs_st_exec = state;
    obs_iv      = instr_valid;
    obs_pc_exec = pc;
    exec_done   = 1;
    #1;
    obs_psrc = pc_src;
    if (h) begin
      x.pc = m_pc;
      x.st = 2'd3;
    end else begin
      x.pc = model_next_pc(m_pc, br, z, j, off, tgt);
      x.st = 2'd1;
    end
    if (br && z && !j && !h && m_cnt != 16'hFFFF) x.cnt = m_cnt + 16'd1;
    else x.cnt = m_cnt;
    m_pc  = x.pc;
    m_cnt = x.cnt;
    sb.push_back(x);
    @(negedge clk);
    clear_inputs();
    obs_post = {pc, taken_count, state};
  endtask

  task automatic pop_expected(output exp_t ex, output logic ok);
    ok = (sb.size() != 0);
    if (ok) ex = sb.pop_front();
    else ex = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({state, pc, taken_count, imem_req, instr_valid, pc_src} !== {2'd0, RST_PC, 16'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d pc=%h cnt=%h req=%b iv=%b psrc=%b, expected st=0 pc=%h cnt=0 req=0 iv=0 psrc=0",
               state, pc, taken_count, imem_req, instr_valid, pc_src, RST_PC);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got st=%0d, expected st=0", state);
    end
    $display("test_reset done: st=%0d pc=%h cnt=%h", state, pc, taken_count);
  endtask

  task automatic test_sequential();
    logic ok;
    do_start();
    n_cmp++;
    if (state !== 2'd1 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_fetch: got st=%0d req=%b, expected st=1 req=1", state, imem_req);
    end
    issue(0, 0, 0, 0, 32'h0, 26'h0, 2);
    n_cmp++;
    if (obs_req !== 3) begin
      n_fail++;
      $display("FAIL seq_req_cycles: got %0d, expected 3", obs_req);
    end
    n_cmp++;
    if ({obs_st_exec, obs_iv, obs_pc_exec, obs_psrc} !== {2'd2, 1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL seq_exec: got st=%0d iv=%b pc=%h psrc=%b, expected st=2 iv=1 pc=0 psrc=0",
               obs_st_exec, obs_iv, obs_pc_exec, obs_psrc);
    end
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e) begin
      n_fail++;
      $display("FAIL seq_retire: got pc=%h cnt=%h st=%0d, expected pc=%h cnt=%h st=%0d",
               obs_post.pc, obs_post.cnt, obs_post.st, e.pc, e.cnt, e.st);
    end
    $display("test_sequential: pc=%h st=%0d req_cycles=%0d", obs_post.pc, obs_post.st, obs_req);
  endtask

  task automatic test_branch();
    logic ok;
    issue(0, 0, 1, 0, 32'h0, 26'h40, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e) begin
      n_fail++;
      $display("FAIL br_setup_jump: got pc=%h cnt=%h st=%0d, expected pc=%h cnt=%h st=%0d",
               obs_post.pc, obs_post.cnt, obs_post.st, e.pc, e.cnt, e.st);
    end
    issue(1, 1, 0, 0, 32'h3, 26'h0, 1);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || e.pc !== 32'h110 || e.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL br_taken: got pc=%h cnt=%h st=%0d, expected pc=%h cnt=%h st=%0d",
               obs_post.pc, obs_post.cnt, obs_post.st, e.pc, e.cnt, e.st);
    end
    n_cmp++;
    if (obs_psrc !== 1'b1 || pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL br_taken_psrc: got during=%b after=%b, expected during=1 after=0", obs_psrc, pc_src);
    end
    issue(0, 0, 1, 0, 32'h0, 26'h40, 0);
    void'(sb.pop_front());
    issue(1, 0, 0, 0, 32'h3, 26'h0, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || obs_psrc !== 1'b0) begin
      n_fail++;
      $display("FAIL br_not_taken: got pc=%h cnt=%h psrc=%b, expected pc=%h cnt=%h psrc=0",
               obs_post.pc, obs_post.cnt, obs_psrc, e.pc, e.cnt);
    end
    $display("test_branch: pc=%h cnt=%h", obs_post.pc, obs_post.cnt);
  endtask

  task automatic test_wrap();
    logic ok;
    issue(0, 0, 1, 0, 32'h0, 26'h0, 0);
    void'(sb.pop_front());
    issue(1, 1, 0, 0, 32'hFFFF_FFFE, 26'h0, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || e.pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_back: got pc=%h cnt=%h, expected pc=%h cnt=%h", obs_post.pc, obs_post.cnt, e.pc, e.cnt);
    end
    issue(0, 0, 0, 0, 32'h0, 26'h0, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || e.pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_plus4: got pc=%h cnt=%h, expected pc=%h cnt=%h", obs_post.pc, obs_post.cnt, e.pc, e.cnt);
    end
    $display("test_wrap: pc=%h cnt=%h", obs_post.pc, obs_post.cnt);
  endtask

  task automatic test_jump_priority();
    logic ok;
    issue(0, 0, 1, 0, 32'h0, 26'h40, 0);
    void'(sb.pop_front());
    issue(1, 1, 0, 0, 32'hFFFF_FFFF, 26'h0, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || e.pc !== 32'h100) begin
      n_fail++;
      $display("FAIL back_branch: got pc=%h cnt=%h, expected pc=%h cnt=%h", obs_post.pc, obs_post.cnt, e.pc, e.cnt);
    end
    issue(0, 0, 1, 0, 32'h0, 26'h10_0000, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || e.pc !== 32'h0040_0000) begin
      n_fail++;
      $display("FAIL jump_far: got pc=%h, expected pc=%h", obs_post.pc, e.pc);
    end
    issue(1, 1, 1, 0, 32'h5, 26'h10, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || obs_psrc !== 1'b0 || e.pc !== 32'h40) begin
      n_fail++;
      $display("FAIL jump_over_branch: got pc=%h cnt=%h psrc=%b, expected pc=%h cnt=%h psrc=0",
               obs_post.pc, obs_post.cnt, obs_psrc, e.pc, e.cnt);
    end
    $display("test_jump_priority: pc=%h cnt=%h", obs_post.pc, obs_post.cnt);
  endtask

  task automatic test_saturation();
    logic ok;
    force dut.r_taken_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_taken_count;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    n_cmp++;
    if (taken_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_preload: got cnt=%h, expected cnt=ffff", taken_count);
    end
    issue(1, 1, 0, 0, 32'h0, 26'h0, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || obs_post.cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got pc=%h cnt=%h, expected pc=%h cnt=%h", obs_post.pc, obs_post.cnt, e.pc, e.cnt);
    end
    $display("test_saturation: pc=%h cnt=%h", obs_post.pc, obs_post.cnt);
  endtask

  task automatic test_halt();
    logic ok;
    logic [31:0] pc_hold;
    issue(1, 1, 1, 1, 32'h7, 26'h3FF, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || e.st !== 2'd3) begin
      n_fail++;
      $display("FAIL halt_enter: got pc=%h cnt=%h st=%0d, expected pc=%h cnt=%h st=%0d",
               obs_post.pc, obs_post.cnt, obs_post.st, e.pc, e.cnt, e.st);
    end
    pc_hold = m_pc;
    start = 1; imem_ack = 1; exec_done = 1; branch = 1; zero = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({state, pc, imem_req, instr_valid} !== {2'd3, pc_hold, 2'b00}) begin
        n_fail++;
        $display("FAIL halt_stay[%0d]: got st=%0d pc=%h req=%b iv=%b, expected st=3 pc=%h req=0 iv=0",
                 k, state, pc, imem_req, instr_valid, pc_hold);
      end
    end
    clear_inputs();
    $display("test_halt: st=%0d pc=%h cnt=%h", state, pc, taken_count);
  endtask

  task automatic test_reset_mid_exec();
    logic ok;
    do_reset();
    do_start();
    issue(1, 1, 0, 0, 32'h1, 26'h0, 0);
    pop_expected(e, ok);
    n_cmp++;
    if (!ok || obs_post !== e || e.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_pre_branch: got pc=%h cnt=%h, expected pc=%h cnt=%h", obs_post.pc, obs_post.cnt, e.pc, e.cnt);
    end
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    exec_done = 1; branch = 1; zero = 1; reset = 1;
    @(negedge clk);
    clear_inputs();
    reset = 0;
    n_cmp++;
    if ({state, pc, taken_count, imem_req, instr_valid, pc_src} !== {2'd0, RST_PC, 16'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_mid_exec: got st=%0d pc=%h cnt=%h req=%b iv=%b psrc=%b, expected st=0 pc=%h cnt=0 req=0 iv=0 psrc=0",
               state, pc, taken_count, imem_req, instr_valid, pc_src, RST_PC);
    end
    imem_ack = 1; exec_done = 1; jump = 1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({state, pc, imem_req} !== {2'd0, RST_PC, 1'b0}) begin
      n_fail++;
      $display("FAIL stray_ack_idle: got st=%0d pc=%h req=%b, expected st=0 pc=%h req=0", state, pc, imem_req, RST_PC);
    end
    clear_inputs();
    $display("test_reset_mid_exec: st=%0d pc=%h cnt=%h", state, pc, taken_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_jump_priority();
    test_saturation();
    test_halt();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin fetching from the current PC.
- imem_req  output  1  instruction-memory fetch request.
- imem_ack  input  1  instruction memory has returned the instruction at pc.
- instr_valid  output  1  datapath is executing the instruction at pc.
- exec_done  input  1  datapath has finished the current instruction; branch, zero, jump and halt are valid.
- branch  input  1  current instruction is a conditional branch.
- zero  input  1  ALU zero flag.
- jump  input  1  current instruction is a jump.
- halt  input  1  current instruction stops the sequencer.
- branch_offset  input  32  sign-extended word offset.
- jump_target  input  26  jump index field.
- pc  output  32  current program counter.
- pc_src  output  1  branch-taken select (branch AND zero, qualified as in REQ-009).
- taken_count  output  16  count of taken branches, saturating.
- state  output  2  current FSM state encoding.

Function
REQ-003 The FSM SHALL have four states: IDLE=2'd0, FETCH=2'd1, EXEC=2'd2, HALTED=2'd3, and the state output SHALL equal the current state.
REQ-004 IDLE: start=1 SHALL move the FSM to FETCH on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-005 imem_req SHALL be 1 exactly while the state is FETCH (Moore output).
REQ-006 FETCH: imem_ack=1 SHALL move the FSM to EXEC; the FSM SHALL wait in FETCH indefinitely for imem_ack.
REQ-007 instr_valid SHALL be 1 exactly while the state is EXEC.
REQ-008 EXEC: the FSM SHALL hold EXEC until exec_done=1.
REQ-009 pc_src SHALL be combinational: (state==EXEC) & exec_done & branch & zero & ~jump.
REQ-010 EXEC with exec_done=1, halt=0: the block SHALL load the next PC and enter FETCH, with next-PC priority:
- jump: {pc_plus4[31:28], jump_target, 2'b00}
- else pc_src: pc + 4 + (branch_offset << 2), modulo 2^32
- else pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-011 EXEC with exec_done=1, halt=1: the block SHALL enter HALTED with pc unchanged; halt SHALL override jump and branch.
REQ-012 HALTED SHALL be left only by reset; start SHALL be ignored in HALTED.
REQ-013 taken_count SHALL increment by 1 on each edge where pc_src=1 and halt=0, and SHALL saturate at 16'hFFFF.
REQ-014 The block SHALL ignore the following inputs:
- imem_ack outside FETCH
- exec_done, branch, zero, jump and halt outside EXEC
- start outside IDLE.
REQ-015 pc SHALL change only on the EXEC completion edge of REQ-010 or on reset.

Reset
REQ-016 On any edge with reset=1, the block SHALL apply these values, overriding every other input and any state, including mid-FETCH or mid-EXEC:
- state=IDLE
- pc=RESET_PC
- taken_count=0
REQ-017 After reset, the block SHALL drive imem_req=0, instr_valid=0 and pc_src=0 until a start is accepted.

Verification
REQ-018 Sequential flow: reset, start, imem_ack after 3 cycles, exec_done with no branch or jump -> pc 0x0 then 0x4; imem_req high for exactly 3 cycles; state sequence IDLE, FETCH, EXEC, FETCH.
REQ-019 Branch taken and not taken:
- pc=0x100, branch=1, zero=1, offset=0x3 -> pc=0x110, pc_src=1 for one cycle, taken_count=1.
- Same stimulus with zero=0 -> pc=0x104, taken_count unchanged.
REQ-020 Backward branch and jump priority:
- pc=0x100, offset=0xFFFF_FFFF, branch=1, zero=1 -> pc=0x100.
- pc=0x0040_0000, jump=1, jump_target=0x10, branch=1, zero=1 -> pc=0x0000_0040, pc_src=0, taken_count unchanged.
REQ-021 Halt and saturation:
- halt=1 with exec_done and jump=1 -> HALTED, pc unchanged, start ignored for 10 cycles.
- With taken_count forced to 0xFFFF, a further taken branch -> taken_count stays 0xFFFF.
REQ-022 Reset mid-operation: reset asserted in EXEC while exec_done=1, branch=1, zero=1 -> next cycle state=IDLE, pc=RESET_PC, taken_count=0, imem_req=0; stray imem_ack in IDLE -> no state change.
